// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor and its later siblings.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A 1-bit operand still needs a 1-bit counter, hence the floor of 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_if.sv
// Operand and result handshake bundle for the serial subtractor; master drives operands, slave returns results.
interface serial_ripple_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             bout;

    modport master (
        output in_valid, x1, x2, bin, out_ready,
        input  in_ready, out_valid, y, bout
    );

    modport slave (
        input  in_valid, x1, x2, bin, out_ready,
        output in_ready, out_valid, y, bout
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor d = a - b - c with borrow-out bo; purely combinational, zero latency.
// No handshake or backpressure; the enclosing serial block sequences it.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ c;
    assign bo = (~a & b) | (~(a ^ b) & c);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial y = x1 - x2 - bin, LSB first; out_valid rises WIDTH edges after accept.
// Busy blocks in_ready; result holds in DONE until out_ready, so issue interval is WIDTH+2.
module serial_ripple_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_ripple_subtractor_if.slave   bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr_x1;
    logic [WIDTH-1:0] sr_x2;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] y_q;
    logic             bout_q;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             borrow_nxt;
    logic [WIDTH:0]   res_cat;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept;
    logic             last_bit;

    full_subtractor u_fs (
        .a  (sr_x1[0]),
        .b  (sr_x2[0]),
        .c  (borrow),
        .d  (d),
        .bo (borrow_nxt)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    assign res_cat = {d, sr_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state == IDLE);
        out_valid_c = (state == DONE);
        accept      = in_ready_c && bus.in_valid;
        last_bit    = (state == RUN) && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_x1  <= '0;
            sr_x2  <= '0;
            sr_d   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            y_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            sr_x1  <= bus.x1;
            sr_x2  <= bus.x2;
            borrow <= bus.bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            sr_x1  <= sr_x1 >> 1;
            sr_x2  <= sr_x2 >> 1;
            sr_d   <= res_cat[WIDTH:1];
            borrow <= borrow_nxt;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                y_q    <= res_cat[WIDTH:1];
                bout_q <= borrow_nxt;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.y         = y_q;
    assign bus.bout      = bout_q;
endmodule
